// File: rtl/mem_access_pkg.sv
// Shared definitions for the MEM-stage access controller: access modes, FSM states, RAM size.
// Latency: none (types, constants and a pure helper function only).
// Backpressure: not applicable.
package mem_access_pkg;

    localparam int DATA_RAM_BYTES = 256;

    typedef enum logic [1:0] {
        MODE_BYTE  = 2'b00,
        MODE_HALF  = 2'b01,
        MODE_WORD  = 2'b10,
        MODE_DWORD = 2'b11
    } mode_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        BEAT0 = 3'd1,
        GAP   = 3'd2,
        BEAT1 = 3'd3,
        RESP  = 3'd4
    } state_t;

    // True when the access is not naturally aligned or falls outside the data RAM.
    function automatic logic is_misaligned(input mode_t mode, input logic [31:0] addr);
        logic bad;
        bad = (addr >= 32'(DATA_RAM_BYTES));
        case (mode)
            MODE_HALF:  bad = bad | addr[0];
            MODE_WORD:  bad = bad | (addr[1:0] != 2'b00);
            MODE_DWORD: bad = bad | (addr[2:0] != 3'b000);
            default:    bad = bad;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_load_extend.sv
// Load data extension: byte/halfword sign- or zero-extended, word/doubleword passed through.
// Latency: combinational.
// Backpressure: none.
module mem_load_extend
    import mem_access_pkg::*;
(
    input  logic [31:0] data_in,
    input  mode_t       mode,
    input  logic        sign_ext,
    output logic [31:0] data_out
);

    // Select the extension width from the access mode.
    always_comb begin
        data_out = data_in;
        case (mode)
            MODE_BYTE: data_out = {{24{sign_ext & data_in[7]}}, data_in[7:0]};
            MODE_HALF: data_out = {{16{sign_ext & data_in[15]}}, data_in[15:0]};
            default:   data_out = data_in;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage access controller for a big-endian 256x8 RAM; doublewords split into two word beats.
// Latency: accept->rsp_valid 2 cycles (single beat), 4 (doubleword), 1 (rejected, MEM_ACCESS_ALIGN_CHECK_EN).
// Backpressure: req_ready high only in IDLE; requests offered while busy are dropped, not queued.
module mem_access_ctrl
    import mem_access_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [1:0]  req_mode,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata_hi,
    input  logic [31:0] req_wdata_lo,
    output logic        req_ready,
    output logic        rsp_valid,
    output logic        rsp_err,
    output logic [31:0] rsp_rdata_hi,
    output logic [31:0] rsp_rdata_lo,
    output logic        mem_enable,
    output logic        mem_rw,
    output logic [1:0]  mem_mode,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    state_t      state_q;
    state_t      state_d;
    logic        accept;
    logic        reject;
    logic        write_q;
    logic        signed_q;
    mode_t       mode_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_hi_q;
    logic [31:0] wdata_lo_q;
    logic [31:0] rdata_hi_q;
    logic [31:0] rdata_lo_q;
    logic [31:0] ext_data;

    assign accept = req_valid && (state_q == IDLE);

`ifdef MEM_ACCESS_ALIGN_CHECK_EN
    logic err_q;

    assign reject = is_misaligned(mode_t'(req_mode), req_addr);

    // Remember whether the accepted access was rejected so RESP can flag it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (accept) begin
            err_q <= reject;
        end
    end

    assign rsp_err = (state_q == RESP) && err_q;
`else
    assign reject  = 1'b0;
    assign rsp_err = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and RAM/handshake outputs; mem_* are zero outside the beat states.
    always_comb begin
        state_d    = state_q;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        mem_enable = 1'b0;
        mem_rw     = 1'b0;
        mem_mode   = 2'b00;
        mem_addr   = 32'h0;
        mem_wdata  = 32'h0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_d = reject ? RESP : BEAT0;
                end
            end
            BEAT0: begin
                mem_enable = 1'b1;
                mem_rw     = write_q;
                mem_mode   = (mode_q == MODE_DWORD) ? MODE_WORD : mode_q;
                mem_addr   = addr_q;
                if (write_q) begin
                    mem_wdata = (mode_q == MODE_DWORD) ? wdata_hi_q : wdata_lo_q;
                end
                state_d = (mode_q == MODE_DWORD) ? GAP : RESP;
            end
            GAP: begin
                // Enable drops for one cycle so the RAM sees a fresh edge for the second beat.
                state_d = BEAT1;
            end
            BEAT1: begin
                mem_enable = 1'b1;
                mem_rw     = write_q;
                mem_mode   = MODE_WORD;
                mem_addr   = addr_q + 32'd4;
                if (write_q) begin
                    mem_wdata = wdata_lo_q;
                end
                state_d = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Latch the request fields on acceptance; they stay put for the whole access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            write_q    <= 1'b0;
            signed_q   <= 1'b0;
            mode_q     <= MODE_BYTE;
            addr_q     <= 32'h0;
            wdata_hi_q <= 32'h0;
            wdata_lo_q <= 32'h0;
        end else if (accept) begin
            write_q    <= req_write;
            signed_q   <= req_signed;
            mode_q     <= mode_t'(req_mode);
            addr_q     <= req_addr;
            wdata_hi_q <= req_wdata_hi;
            wdata_lo_q <= req_wdata_lo;
        end
    end

    mem_load_extend u_load_extend (
        .data_in  (mem_rdata),
        .mode     (mode_q),
        .sign_ext (signed_q),
        .data_out (ext_data)
    );

    // Capture load data at the end of each beat; cleared on acceptance so stores/errors return 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_hi_q <= 32'h0;
            rdata_lo_q <= 32'h0;
        end else if (accept) begin
            rdata_hi_q <= 32'h0;
            rdata_lo_q <= 32'h0;
        end else if ((state_q == BEAT0) && !write_q) begin
            if (mode_q == MODE_DWORD) begin
                rdata_hi_q <= mem_rdata;
            end else begin
                rdata_lo_q <= ext_data;
            end
        end else if ((state_q == BEAT1) && !write_q) begin
            rdata_lo_q <= mem_rdata;
        end
    end

    assign rsp_rdata_hi = rdata_hi_q;
    assign rsp_rdata_lo = rdata_lo_q;

endmodule
